// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI master model / host logic and the spi_slave responder.
// Carries the serial pins plus the local load/status side.
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] inload;
  logic [1:0]       Mode;
  logic             sclk;
  logic             CS_n;
  logic             MOSI;
  logic             MISO;
  logic             MISO_oe;
  logic [WIDTH-1:0] Slave_SR;
  logic [WIDTH-1:0] rx_data;
  logic             Done;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  load, inload, Mode, sclk, CS_n, MOSI,
    output MISO, MISO_oe, Slave_SR, rx_data, Done, frame_err, busy
  );

  modport master (
    output load, inload, Mode, sclk, CS_n, MOSI,
    input  MISO, MISO_oe, Slave_SR, rx_data, Done, frame_err, busy
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI responder: all four modes, MSB-first, full-duplex WIDTH-bit frames.
// sclk, CS_n and MOSI are resynchronised into clk; every action happens on a detected edge.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // Synchroniser chains and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // Registered state and its next-state values
  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] sr_shift;
  logic             lead_edge, trail_edge, sample_edge, shift_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // Edge roles come from the mode latched at frame start, never from the live Mode pins
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;
  assign sr_shift    = {sr_q[WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      sr_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
        if (bus.load) begin
          sr_d = bus.inload;
        end
        if (cs_fall) begin
          state_d = ACTIVE;
          mode_d  = bus.Mode;
          cnt_d   = '0;
          oe_d    = 1'b1;
          // CPHA=0 masters sample on the first edge, so bit MSB must already be on the wire
          if (!bus.Mode[0]) begin
            miso_d = sr_d[WIDTH-1];
          end
        end
      end

      ACTIVE: begin
        if (sample_edge) begin
          sr_d = sr_shift;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            rx_d   = sr_shift;
            done_d = 1'b1;
            cnt_d  = '0;
            if (!mode_q[0]) begin
              miso_d = sr_shift[WIDTH-1];
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          miso_d = sr_q[WIDTH-1];
        end

        // A release coinciding with the final sample still counts as a clean frame
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          ferr_d  = (cnt_d != '0);
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.MISO      = miso_q;
  assign bus.MISO_oe   = oe_q;
  assign bus.Slave_SR  = sr_q;
  assign bus.rx_data   = rx_q;
  assign bus.Done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q == ACTIVE);

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder for the other end of the link driven by the SPI Master. It oversamples the master's sclk, chip select and MOSI in the system clk domain and supports all four SPI modes. Each frame is full-duplex, MSB-first and WIDTH bits long. The block shifts out a preloaded byte on MISO while capturing MOSI, then flags completion with a one-cycle Done pulse.

Parameters:
WIDTH, 8, frame and shift-register width in bits
SYNC_STAGES, 2, synchronizer flops on sclk, CS_n and MOSI (minimum 2)

Ports:
clk  input  1  system clock; all logic on posedge clk
reset  input  1  asynchronous, active-high reset
load  input  1  in IDLE, copy inload into Slave_SR
inload  input  WIDTH  transmit data for the next frame
Mode  input  2  SPI mode: Mode[1]=CPOL, Mode[0]=CPHA
sclk  input  1  serial clock from the master (asynchronous to clk)
CS_n  input  1  active-low chip select from the master (Slave_I/II/III line)
MOSI  input  1  serial data from the master
MISO  output  1  serial data to the master
MISO_oe  output  1  MISO drive enable; 1 while selected
Slave_SR  output  WIDTH  live shift register
rx_data  output  WIDTH  last complete received frame
Done  output  1  one-cycle pulse at frame completion
frame_err  output  1  one-cycle pulse when CS_n rises mid-frame
busy  output  1  1 while in ACTIVE

Behaviour:
- Reset (asynchronous): state=IDLE; Slave_SR, rx_data and bit_cnt = 0; MISO=0; MISO_oe=0; Done=0; frame_err=0; busy=0; synchronizer flops preset to sclk=0, CS_n=1, MOSI=0.
- Input path:
  - sclk, CS_n and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected on the synced sclk against its previous value.
  - Pin-to-internal-event latency is SYNC_STAGES+1 clk.
- Timing requirement: each sclk half-period must be at least SYNC_STAGES+3 clk periods. Behaviour with faster sclk is undefined.
- Edge mapping:
  - The leading edge is the idle-to-active transition: rising for CPOL=0, falling for CPOL=1.
  - For CPHA=0, the sample edge is the leading edge and the shift edge is the trailing edge.
  - For CPHA=1, the sample edge is the trailing edge and the shift edge is the leading edge.
- IDLE state:
  - busy=0, MISO_oe=0, MISO=0.
  - load=1 sets Slave_SR<=inload.
  - A synced CS_n falling edge moves the state to ACTIVE. Mode is latched, bit_cnt is set to 0, and MISO_oe is set to 1.
  - If CPHA=0, MISO<=Slave_SR[WIDTH-1] in the same cycle.
  - If load and the CS_n fall occur in the same cycle, inload is used: Slave_SR<=inload and MISO<=inload[WIDTH-1].
- ACTIVE state:
  - load is ignored, and Mode changes are ignored until the next frame.
  - Shift edge: MISO<=Slave_SR[WIDTH-1].
  - Sample edge: Slave_SR<={Slave_SR[WIDTH-2:0], MOSI_sync} and bit_cnt increments.
- Frame completion:
  - On the WIDTH-th sample edge: rx_data<=the shifted value, Done=1 for exactly the next clk cycle, and bit_cnt wraps to 0.
  - The state stays ACTIVE while CS_n is low. Back-to-back frames transmit the just-received byte (echo) unless the master releases CS_n.
  - For CPHA=0 back-to-back, MISO<=new Slave_SR[WIDTH-1] on the completing sample edge.
- CS_n rise (synced):
  - The state returns to IDLE, with MISO_oe=0 and MISO=0.
  - If bit_cnt!=0, frame_err pulses for 1 cycle, no Done is issued, rx_data is unchanged and Slave_SR keeps its partial content.
  - A CS_n rise in the same cycle as the completing sample edge counts as a complete frame: Done=1, frame_err=0.
- Glitches: sclk edges while CS_n is high are ignored. The master must hold sclk at CPOL idle level when CS_n falls.
- Reset mid-frame aborts immediately to reset values. No Done or frame_err is issued.

Test Plan:
1. Mode 0: load inload=8'hA5; master sends 8'h3C with CS_n low for 8 sclk -> MISO bits 1,0,1,0,0,1,0,1 MSB-first; rx_data=8'h3C; exactly one Done pulse; Slave_SR=8'h3C.
2. Modes 1, 2 and 3 each: inload=8'h96, master sends 8'hF0 -> rx_data=8'hF0 and master receives 8'h96 in every mode; MISO changes only on the mode's shift edge.
3. Back-to-back, mode 0: inload=8'h81, master sends 8'h55 then 8'hAA with CS_n held low -> two Done pulses; rx_data=8'h55 then 8'hAA; second MISO frame=8'h55.
4. Abort: CS_n rises after 5 sclk edges, prior rx_data=8'h00 -> frame_err one pulse, Done=0, rx_data=8'h00, state IDLE, MISO_oe=0.
5. load=1 with inload=8'hFF during ACTIVE (frame started with 8'h0F) -> transmitted frame=8'h0F, Slave_SR is not overwritten by load.
6. reset=1 at bit 4, mode 3 -> all outputs 0 within the same cycle, MISO_oe=0. The next full frame with inload=8'hC3 transmits 8'hC3 correctly.
